controle_display: RTL and testbench
===================================

// Module: controle_display
// PURPOSE
//   Sequencer that feeds the two-digit 7-segment decoder from the CPU output path.
//   - Accepts a signed binary word through a valid/ready handshake.
//   - Converts it serially (repeated subtraction by 10) into sign / tens / units.
//   - Holds the result until the next accepted word.
//   - Its three outputs drive the decoder's sinal/dezena/unidade inputs in the parent.
// PARAMETERS
//   LARGURA     32  width of the signed two's-complement input word
//   APAGA_ZERO  1   1: tens digit shows blank when it is 0; 0: shows "0"
// PORTS
//   clock          in   1          single system clock, all state updates on rising edge
//   reset          in   1          synchronous, active-high; sampled on rising edge of clock
//   valor          in   LARGURA    signed value to display
//   valor_valido   in   1          request; accepted when valor_valido & pronto at a rising edge
//   pronto         out  1          1 only in ESPERA; otherwise 0
//   atualizado     out  1          one-cycle pulse; outputs below changed at this edge
//   sinal          out  1          1 = negative (display minus)
//   dezena         out  4          tens code: 0-9 digit, 4'b1010 blank, 4'b1111 dash
//   unidade        out  4          units code: same encoding as dezena
// BEHAVIOUR
//   Reset (any state, including mid-conversion):
//     - state <= ESPERA; pronto=1, atualizado=0, sinal=0.
//     - dezena=4'b1010 (blank), unidade=4'b0000; the display shows " 0".
//     - Internal registers are cleared and any in-flight conversion is discarded.
//   FSM states: ESPERA, MODULO, DIVIDE, ATUALIZA.
//   ESPERA: on valor_valido at edge T: capture valor -> reg_v, go MODULO. Otherwise hold.
//   MODULO (edge T+1):
//     - neg <= reg_v[LARGURA-1].
//     - resto <= |reg_v| as LARGURA-bit unsigned; the most negative value maps to 2^(LARGURA-1).
//     - cont <= 0.
//     - If |reg_v| > 99: erro <= 1, go ATUALIZA. Otherwise erro <= 0, go DIVIDE.
//   DIVIDE: if resto >= 10: resto <= resto-10, cont <= cont+1, stay. Otherwise go ATUALIZA.
//     - cont is 4 bits and never exceeds 9.
//   ATUALIZA: register outputs, pulse atualizado (high exactly this one edge), go ESPERA.
//     - erro: sinal=0, dezena=unidade=4'b1111 (display shows "--").
//     - Otherwise: sinal=neg, unidade=resto[3:0], dezena=cont.
//       If APAGA_ZERO and cont==0, dezena=4'b1010 instead.
//   Latency:
//     - In range, q=floor(|v|/10): outputs valid after edge T+3+q (3..12 cycles).
//     - Overflow: outputs valid after edge T+2.
//   Outputs are registered; they change only at the ATUALIZA edge or at reset.
//   pronto=0 from edge T until the edge leaving ATUALIZA; requests in that window are ignored (no queue).
//   A new request may be accepted the cycle after atualizado.
//   Zero input: sinal=0, never a negative zero.
//   reset and valor_valido in the same cycle: reset wins, nothing is captured.
// STRUCTURE
//   Shared header display_defs.vh holds:
//     - codes BLANK=4'b1010, TRACO=4'b1111;
//     - FSM encodings ESPERA=2'd0, MODULO=2'd1, DIVIDE=2'd2, ATUALIZA=2'd3;
//     - limit MAX_EXIBIVEL=99.
//   No sub-module inside this block; FSM, subtractor and output registers are flat.
//   The parent instantiates the existing 7-segment decoder next to it.
// TESTING
//   1. Reset, then idle -> sinal=0, dezena=1010, unidade=0000, pronto=1, atualizado=0.
//   2. valor=47 at edge T -> at edge T+7: dezena=4, unidade=7, sinal=0;
//      atualizado high only there; pronto low from T to T+7.
//   3. valor=-5 (APAGA_ZERO=1) -> at edge T+3: sinal=1, dezena=1010, unidade=5.
//      Repeat with APAGA_ZERO=0 -> dezena=0000.
//   4. valor=100, then valor=-2^(LARGURA-1) -> each at edge T+2: sinal=0, dezena=unidade=1111.
//      Then valor=-99 -> at edge T+12: sinal=1, dezena=9, unidade=9.
//   5. valor=99 accepted; valor=3 with valor_valido held during busy -> 99 displayed first.
//      The 3 is accepted only once pronto returns; no request is lost or doubled.
//   6. Assert reset in DIVIDE while converting 85 -> next edge shows the reset values.
//      No atualizado pulse for 85; a new 12 is then accepted and shows 1,2.

Source files
------------

// File: rtl/controle_display_pkg.sv
// Shared definitions for the display sequencer: digit codes, range limit and FSM states.
package controle_display_pkg;

   // Digit codes understood by the 7-segment decoder besides 0-9
   localparam logic [3:0] BLANK = 4'b1010;
   localparam logic [3:0] TRACO = 4'b1111;

   // Largest magnitude that fits in two decimal digits
   localparam int unsigned MAX_EXIBIVEL = 32'd99;

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      MODULO   = 2'd1,
      DIVIDE   = 2'd2,
      ATUALIZA = 2'd3
   } estado_t;

endpackage

// File: rtl/controle_display.sv
// Display sequencer: accepts a signed word, converts it by repeated subtraction
// into sign / tens / units codes and holds them for the 7-segment decoder.
module controle_display
   import controle_display_pkg::*;
#(
   parameter int LARGURA    = 32,
   parameter bit APAGA_ZERO = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] valor,
   input  logic               valor_valido,
   output logic               pronto,
   output logic               atualizado,
   output logic               sinal,
   output logic [3:0]         dezena,
   output logic [3:0]         unidade
);

   localparam logic [LARGURA-1:0] LIMITE = LARGURA'(MAX_EXIBIVEL);
   localparam logic [LARGURA-1:0] DEZ    = LARGURA'(32'd10);
   localparam logic [LARGURA-1:0] UM     = LARGURA'(32'd1);

   estado_t            estado;
   estado_t            proximo;
   logic [LARGURA-1:0] reg_v;
   logic [LARGURA-1:0] resto;
   logic [LARGURA-1:0] modulo_v;
   logic [3:0]         cont;
   logic               neg;
   logic               erro;

   // Magnitude as unsigned; the most negative value wraps to 2^(LARGURA-1)
   function automatic logic [LARGURA-1:0] valor_absoluto(input logic [LARGURA-1:0] v);
      if (v[LARGURA-1]) begin
         return (~v) + UM;
      end else begin
         return v;
      end
   endfunction

   assign modulo_v = valor_absoluto(reg_v);
   assign pronto   = (estado == ESPERA);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= ESPERA;
      end else begin
         estado <= proximo;
      end
   end

   // Next-state logic
   always_comb begin
      proximo = estado;
      case (estado)
         ESPERA: begin
            if (valor_valido) begin
               proximo = MODULO;
            end else begin
               proximo = ESPERA;
            end
         end
         MODULO: begin
            if (modulo_v > LIMITE) begin
               proximo = ATUALIZA;
            end else begin
               proximo = DIVIDE;
            end
         end
         DIVIDE: begin
            if (resto >= DEZ) begin
               proximo = DIVIDE;
            end else begin
               proximo = ATUALIZA;
            end
         end
         ATUALIZA: proximo = ESPERA;
         default:  proximo = ESPERA;
      endcase
   end

   // Conversion datapath: capture, take magnitude, subtract tens one per cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         reg_v <= '0;
         resto <= '0;
         cont  <= 4'd0;
         neg   <= 1'b0;
         erro  <= 1'b0;
      end else begin
         case (estado)
            ESPERA: begin
               if (valor_valido) begin
                  reg_v <= valor;
               end
            end
            MODULO: begin
               neg   <= reg_v[LARGURA-1];
               resto <= modulo_v;
               cont  <= 4'd0;
               erro  <= (modulo_v > LIMITE);
            end
            DIVIDE: begin
               if (resto >= DEZ) begin
                  resto <= resto - DEZ;
                  cont  <= cont + 4'd1;
               end
            end
            ATUALIZA: begin
               reg_v <= reg_v;
            end
            default: begin
               reg_v <= reg_v;
            end
         endcase
      end
   end

   // Output registers: loaded only in ATUALIZA, with a one-cycle update pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         atualizado <= 1'b0;
         sinal      <= 1'b0;
         dezena     <= BLANK;
         unidade    <= 4'b0000;
      end else if (estado == ATUALIZA) begin
         atualizado <= 1'b1;
         if (erro) begin
            sinal   <= 1'b0;
            dezena  <= TRACO;
            unidade <= TRACO;
         end else begin
            sinal   <= neg;
            unidade <= resto[3:0];
            if (APAGA_ZERO && (cont == 4'd0)) begin
               dezena <= BLANK;
            end else begin
               dezena <= cont;
            end
         end
      end else begin
         atualizado <= 1'b0;
      end
   end

endmodule

// File: tb/tb_controle_display.sv
// Scoreboard bench for controle_display: two instances (tens blanking on/off)
// share the stimulus; a decimal reference model predicts display and latency.
module tb_controle_display;

   logic        clock;
   logic        reset;
   logic [31:0] valor;
   logic        valor_valido;

   logic       pronto0, atual0, sinal0;
   logic [3:0] dez0, uni0;
   logic       pronto1, atual1, sinal1;
   logic [3:0] dez1, uni1;

   typedef struct {
      logic signed [31:0] v;
      int                 t;
   } pedido_t;

   pedido_t fila[$];
   int      ciclo = 0;
   int      checks = 0;
   int      fails = 0;

   logic       exp_s[2];
   logic [3:0] exp_d[2];
   logic [3:0] exp_u[2];

   controle_display #(.LARGURA(32), .APAGA_ZERO(1'b1)) dut0 (
      .clock(clock), .reset(reset), .valor(valor), .valor_valido(valor_valido),
      .pronto(pronto0), .atualizado(atual0), .sinal(sinal0),
      .dezena(dez0), .unidade(uni0)
   );

   controle_display #(.LARGURA(32), .APAGA_ZERO(1'b0)) dut1 (
      .clock(clock), .reset(reset), .valor(valor), .valor_valido(valor_valido),
      .pronto(pronto1), .atualizado(atual1), .sinal(sinal1),
      .dezena(dez1), .unidade(uni1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) ciclo <= ciclo + 1;

   // Reference: decimal digits of |v|, two-digit limit, blank leading zero if asked
   function automatic logic [8:0] modelo(input logic signed [31:0] v, input bit az);
      longint a;
      longint q;
      logic [3:0] d;
      logic [3:0] u;
      a = v;
      if (a < 0) a = -a;
      if (a > 99) return {1'b0, 4'hF, 4'hF};
      q = a / 10;
      u = 4'(a % 10);
      d = (az && q == 0) ? 4'hA : 4'(q);
      return {(v < 0), d, u};
   endfunction

   function automatic int latencia(input logic signed [31:0] v);
      longint a;
      a = v;
      if (a < 0) a = -a;
      if (a > 99) return 2;
      return 3 + int'(a / 10);
   endfunction

   task automatic verifica(input string nome, input logic [31:0] got, input logic [31:0] esp);
      checks++;
      if (got !== esp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, esp, $time);
      end
   endtask

   task automatic valores_reset();
      for (int k = 0; k < 2; k++) begin
         exp_s[k] = 1'b0;
         exp_d[k] = 4'b1010;
         exp_u[k] = 4'b0000;
      end
   endtask

   // Monitor: pop on each update pulse, then check held outputs and ready every cycle
   pedido_t p;
   logic [8:0] e;
   always @(negedge clock) begin
      if (atual0 || atual1) begin
         verifica("atualizado_both", {31'd0, atual0 & atual1}, 32'd1);
         if (fila.size() == 0) begin
            verifica("atualizado_spurious", 32'd1, 32'd0);
         end else begin
            p = fila.pop_front();
            verifica("latency", ciclo - p.t, latencia(p.v));
            e = modelo(p.v, 1'b1);
            exp_s[0] = e[8]; exp_d[0] = e[7:4]; exp_u[0] = e[3:0];
            e = modelo(p.v, 1'b0);
            exp_s[1] = e[8]; exp_d[1] = e[7:4]; exp_u[1] = e[3:0];
         end
      end
      verifica("sinal0",   {31'd0, sinal0}, {31'd0, exp_s[0]});
      verifica("dezena0",  {28'd0, dez0},   {28'd0, exp_d[0]});
      verifica("unidade0", {28'd0, uni0},   {28'd0, exp_u[0]});
      verifica("sinal1",   {31'd0, sinal1}, {31'd0, exp_s[1]});
      verifica("dezena1",  {28'd0, dez1},   {28'd0, exp_d[1]});
      verifica("unidade1", {28'd0, uni1},   {28'd0, exp_u[1]});
      verifica("pronto0",  {31'd0, pronto0}, {31'd0, fila.size() == 0});
      verifica("pronto1",  {31'd0, pronto1}, {31'd0, fila.size() == 0});
   end

   // Offer v until the DUT takes it; record the acceptance edge
   task automatic enviar(input logic [31:0] v);
      bit pr;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clock);
         valor = v;
         valor_valido = 1'b1;
         pr = pronto0;
         @(posedge clock);
         #1;
         if (pr) begin
            fila.push_back('{v, ciclo});
            ok = 1'b1;
         end
      end
      if (!ok) verifica("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic ocioso(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         valor_valido = 1'b0;
         valor = $urandom;
      end
   endtask

   // One-edge reset, optionally with a simultaneous request that must be dropped
   task automatic aplicar_reset(input bit com_pedido);
      @(negedge clock);
      reset = 1'b1;
      valor_valido = com_pedido;
      valor = 32'd7;
      @(posedge clock);
      #1;
      fila.delete();
      valores_reset();
      @(negedge clock);
      reset = 1'b0;
      valor_valido = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      reset = 1'b1;
      valor = 32'd0;
      valor_valido = 1'b0;
      valores_reset();
      aplicar_reset(1'b1);
      ocioso(3);

      enviar(32'd47);
      ocioso(10);
      enviar(-32'sd5);
      ocioso(5);
      enviar(32'd100);
      ocioso(4);
      enviar(32'h8000_0000);
      ocioso(4);
      enviar(-32'sd99);
      ocioso(14);
      enviar(32'd0);
      ocioso(5);

      // Back-to-back: 3 is held while 99 converts
      enviar(32'd99);
      enviar(32'd3);
      ocioso(8);

      // Reset while 85 is in DIVIDE, then a fresh request
      enviar(32'd85);
      ocioso(2);
      aplicar_reset(1'b0);
      ocioso(2);
      enviar(32'd12);
      ocioso(6);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) v = $urandom;
         else v = 32'($signed(int'($urandom_range(0, 240)) - 120));
         enviar(v);
         if ($urandom_range(0, 1) == 1) ocioso($urandom_range(1, 14));
      end

      for (int i = 0; i < 100 && fila.size() != 0; i++) @(negedge clock);
      verifica("drain_queue", fila.size(), 32'd0);
      ocioso(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
